// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with one register stage per BLOCK-bit group.
// Optional saturation on signed overflow is enabled by defining CLA_SAT_EN (adds the sat port).

module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] sum,
    output logic             co,
    output logic             cmsb
);
    logic [BLOCK-1:0] p, g;
    logic [BLOCK:0]   c;
    logic             t;

    // Each carry is a flat sum of products of G/P terms, so there is no ripple path within the group.
    always_comb begin
        p = a ^ b;
        g = a & b;
        c = '0;
        c[0] = ci;
        t = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
    end

    assign sum  = p ^ c[BLOCK-1:0];
    assign co   = c[BLOCK];
    assign cmsb = c[BLOCK-1];
endmodule

module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTG = WIDTH / BLOCK;

    if (BLOCK < 1 || BLOCK > 8 || (WIDTH % BLOCK) != 0) begin : g_bad_param
        $error("pipe_cla_adder: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
    end

    logic                       stall, accept;
    logic [NSTG-1:0]            vld_pipe;
    logic [NSTG-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic [NSTG-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [NSTG-1:0]            c_in, c_q;
    logic [NSTG-1:0][BLOCK-1:0] g_sum;
    logic [NSTG-1:0]            g_co, g_cmsb;
    logic [WIDTH-1:0]           s_fin;
    logic                       ovf_fin;
    logic                       cout_r, ovf_r, zero_r;
`ifdef CLA_SAT_EN
    logic [NSTG-1:0]            sat_in, sat_q;
`endif

    assign out_valid = vld_pipe[NSTG-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign a_in[0] = a;
            assign b_in[0] = sub ? ~b : b;
            assign s_in[0] = '0;
            assign c_in[0] = sub | cin;
`ifdef CLA_SAT_EN
            assign sat_in[0] = sat;
`endif
        end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
`ifdef CLA_SAT_EN
            assign sat_in[k] = sat_q[k-1];
`endif
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a    (a_in[k][k*BLOCK +: BLOCK]),
            .b    (b_in[k][k*BLOCK +: BLOCK]),
            .ci   (c_in[k]),
            .sum  (g_sum[k]),
            .co   (g_co[k]),
            .cmsb (g_cmsb[k])
        );
    end

    // Last stage also forms the flags; the clamp replaces its sum before it is registered.
    always_comb begin
        s_nxt = s_in;
        for (int k = 0; k < NSTG; k++) s_nxt[k][k*BLOCK +: BLOCK] = g_sum[k];
        s_fin   = s_nxt[NSTG-1];
        ovf_fin = g_co[NSTG-1] ^ g_cmsb[NSTG-1];
`ifdef CLA_SAT_EN
        // sat selects the signed clamp: a wrapped result with sign bit set was a positive overflow.
        if (sat_in[NSTG-1] && ovf_fin) begin
            s_fin   = s_fin[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
            ovf_fin = 1'b0;
        end
`endif
        s_nxt[NSTG-1] = s_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
`ifdef CLA_SAT_EN
            sat_q    <= '0;
`endif
        end else if (!stall) begin
            vld_pipe <= NSTG'({vld_pipe, accept});
            a_q      <= a_in;
            b_q      <= b_in;
            s_q      <= s_nxt;
            c_q      <= g_co;
            cout_r   <= g_co[NSTG-1];
            ovf_r    <= ovf_fin;
            zero_r   <= ~|s_fin;
`ifdef CLA_SAT_EN
            sat_q    <= sat_in;
`endif
        end
    end

    assign s    = s_q[NSTG-1];
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

    // Operand bits below the active group and the last stage's carry/operands are never consumed.
    logic unused;
`ifdef CLA_SAT_EN
    assign unused = ^{a_in, b_in, c_q[NSTG-1], g_cmsb, sat_q[NSTG-1]};
`else
    assign unused = ^{a_in, b_in, c_q[NSTG-1], g_cmsb};
`endif
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder: driver pushes model results, negedge monitor pops and compares.
// With CLA_SAT_EN defined the sat port is connected and saturating beats are exercised.

module tb_pipe_cla_adder;
    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NSTG  = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, cin, sub, sat;
    logic             out_valid, out_ready, cout, ovf, zero;
    logic [WIDTH-1:0] a, b, s;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   rnd_done;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef CLA_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic ci, input logic sb, input logic st);
        exp_t e;
        int   ures, sres, sa, sbv;
        sa  = $signed(av);
        sbv = $signed(bv);
        if (sb) begin
            ures   = int'(av) - int'(bv);
            sres   = sa - sbv;
            e.cout = (av >= bv);
        end else begin
            ures   = int'(av) + int'(bv) + int'(ci);
            sres   = sa + sbv + int'(ci);
            e.cout = (ures > 65535);
        end
        e.s   = ures[WIDTH-1:0];
        e.ovf = (sres > 32767) || (sres < -32768);
        if (st && e.ovf) begin
            e.s   = (sres > 0) ? 16'h7FFF : 16'h8000;
            e.ovf = 1'b0;
        end
        e.zero = (e.s == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("s", s, mon_e.s);
                    chk("cout", cout, mon_e.cout);
                    chk("ovf", ovf, mon_e.ovf);
                    chk("zero", zero, mon_e.zero);
                    n_out++;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input logic sb, input logic st);
        int tries = 0;
        bit done = 0;
        a = av; b = bv; cin = ci; sub = sb; sat = st; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(av, bv, ci, sb, st));
                done = 1;
            end
            @(posedge clk); #1;
            tries++;
            if (!done && tries > 200) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", lat, NSTG);
        @(posedge clk); #1;

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0);
        drain();

        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out - base, 8);

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
`ifdef CLA_SAT_EN
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`else
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef CLA_SAT_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        send(16'h0003, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
`endif

        send(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
        send(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0);
        a = 16'h0505; b = 16'h0606; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_s", s, 0);
            chk("midrst_in_ready", in_ready, 1);
        end
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
